// File: rtl/dmem_burst_ctrl_pkg.sv
// Shared definitions for the data-memory burst controller: widths, FSM encoding, defaults.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package dmem_burst_ctrl_pkg;

    // Datapath widths
    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = 128;
    localparam int ADDR_W      = 10;
    localparam int BEATS       = 4;
    localparam int CNT_W       = 4;

    // Default wait cycles before the first beat / the write commit
    localparam int LATENCY_DEF = 4;

    // FSM encoding, kept as plain 2-bit constants so older tooling can read it
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_BURST = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Word address of a burst beat: block base from the latched address, beat
    // number in the low bits, so the burst never crosses into the next block.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [1:0]        beat);
        return {base[ADDR_W-1:2], beat};
    endfunction

endpackage

// File: rtl/dmem_burst_ctrl_array.sv
// Data-memory storage: DEPTH x 32-bit words, one write port, one read port.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; contents are deliberately not touched by reset.
module dmem_array
    import dmem_burst_ctrl_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Synchronous write; no reset so stored data survives a controller reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Cache-side data-memory controller: 4-word block fill on read, single-word write-through.
// Latency: read acceptance->ready = LATENCY+5 cycles, write acceptance->ready = LATENCY+1 cycles.
// Backpressure: one request in flight; requests are level-held until the one-cycle ready pulse.
module dmem_burst_ctrl
    import dmem_burst_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,   // legal 1..15, fits the 4-bit counter
    parameter int DEPTH   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_req,
    input  logic               write_req,
    input  logic [ADDR_W-1:0]  word_address,
    input  logic [WORD_W-1:0]  write_data,
    output logic               ready,
    output logic [BLOCK_W-1:0] block_data,
    output logic               busy
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;          // WAIT cycle count, then beat number in BURST
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_data;
    logic              lat_is_read;

    logic              wait_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0] mem_rdata;

    // The write commits on the final WAIT cycle; an async reset drops state to
    // IDLE first, which removes the enable and cancels the pending write.
    assign wait_last = (state == ST_WAIT) && (cnt == WAIT_LAST);
    assign mem_we    = wait_last && !lat_is_read;
    assign mem_raddr = beat_addr(lat_addr, cnt[1:0]);

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (lat_addr),
        .wdata (lat_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // FSM, shared counter and request latches. Reads win a tie with writes;
    // a still-held write is picked up on a later IDLE cycle. DONE always
    // passes through IDLE, giving the requester a cycle to drop its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_is_read <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_req || write_req) begin
                        state       <= ST_WAIT;
                        cnt         <= '0;
                        lat_addr    <= word_address;
                        lat_data    <= write_data;
                        lat_is_read <= read_req;
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= lat_is_read ? ST_BURST : ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cnt == BEAT_LAST) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Block register loads one slot per BURST beat and holds otherwise, so the
    // last completed fill stays visible; reset clears any partial fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_data <= '0;
        end else if (state == ST_BURST) begin
            block_data[{cnt[1:0], 5'd0} +: WORD_W] <= mem_rdata;
        end
    end

    assign ready = (state == ST_DONE);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Directed bench for dmem_burst_ctrl: LATENCY=4 instance for the main sequence, LATENCY=1 instance for the short variant.
// Latency: checks acceptance->ready counts for reads and writes on both instances.
// Backpressure: requests held as levels until ready, then dropped at the sampling point.
module tb_dmem_burst_ctrl;
    import dmem_burst_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;

    logic         rd_a, wr_a, rdy_a, busy_a;
    logic [9:0]   addr_a;
    logic [31:0]  wdat_a;
    logic [127:0] blk_a;

    logic         rd_b, wr_b, rdy_b, busy_b;
    logic [9:0]   addr_b;
    logic [31:0]  wdat_b;
    logic [127:0] blk_b;

    int total = 0;
    int bad   = 0;

    logic [127:0] blk;
    logic [127:0] prev;
    int           lat, idle, pulses;

    dmem_burst_ctrl #(.LATENCY(4), .DEPTH(1024)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .read_req     (rd_a),
        .write_req    (wr_a),
        .word_address (addr_a),
        .write_data   (wdat_a),
        .ready        (rdy_a),
        .block_data   (blk_a),
        .busy         (busy_a)
    );

    dmem_burst_ctrl #(.LATENCY(1), .DEPTH(1024)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .read_req     (rd_b),
        .write_req    (wr_b),
        .word_address (addr_b),
        .write_data   (wdat_b),
        .ready        (rdy_b),
        .block_data   (blk_b),
        .busy         (busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts idle sampling points before the request is taken and busy ones up
    // to and including the ready pulse. Address/data are scrambled on the first
    // busy cycle: the DUT must be working from its latched copies.
    task automatic wait_ready(input bit sel, output int n_lat, output int n_idle);
        bit seen;
        n_lat  = 0;
        n_idle = 0;
        seen   = 1'b0;
        for (int g = 0; g < 60; g++) begin
            @(negedge clk);
            if ((sel ? busy_b : busy_a) === 1'b1) n_lat++;
            else n_idle++;
            if (n_lat == 1) begin
                if (sel) begin addr_b = addr_b ^ 10'h3FF; wdat_b = ~wdat_b; end
                else     begin addr_a = addr_a ^ 10'h3FF; wdat_a = ~wdat_a; end
            end
            if ((sel ? rdy_b : rdy_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_seen", {127'd0, seen}, 128'd1);
    endtask

    task automatic do_write(input bit sel, input logic [9:0] a, input logic [31:0] d);
        int l, i;
        if (sel) begin wr_b = 1'b1; addr_b = a; wdat_b = d; end
        else     begin wr_a = 1'b1; addr_a = a; wdat_a = d; end
        wait_ready(sel, l, i);
        check(sel ? "wr_lat_b" : "wr_lat_a", l, sel ? 2 : 5);
        if (sel) wr_b = 1'b0; else wr_a = 1'b0;
        @(negedge clk);
        check("wr_rdy_drop", {127'd0, sel ? rdy_b : rdy_a}, 128'd0);
        check("wr_idle_busy", {127'd0, sel ? busy_b : busy_a}, 128'd0);
    endtask

    task automatic do_read(input bit sel, input logic [9:0] a, output logic [127:0] b);
        int l, i;
        if (sel) begin rd_b = 1'b1; addr_b = a; end
        else     begin rd_a = 1'b1; addr_a = a; end
        wait_ready(sel, l, i);
        check(sel ? "rd_lat_b" : "rd_lat_a", l, sel ? 6 : 9);
        b = sel ? blk_b : blk_a;
        if (sel) rd_b = 1'b0; else rd_a = 1'b0;
        @(negedge clk);
        check("rd_rdy_drop", {127'd0, sel ? rdy_b : rdy_a}, 128'd0);
        check("rd_blk_hold", sel ? blk_b : blk_a, b);
    endtask

    initial begin
        rst = 1'b1;
        rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdat_a = '0;
        rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdat_b = '0;

        // Reset state on both instances
        @(negedge clk);
        check("rst_ready_a", {127'd0, rdy_a}, 128'd0);
        check("rst_busy_a",  {127'd0, busy_a}, 128'd0);
        check("rst_blk_a",   blk_a, 128'd0);
        check("rst_ready_b", {127'd0, rdy_b}, 128'd0);
        check("rst_blk_b",   blk_b, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload through the write path
        for (int k = 0; k < 4; k++) do_write(0, 10'h020 + 10'(k), 32'hA0 + 32'(k));
        for (int k = 0; k < 3; k++) do_write(0, 10'h3FC + 10'(k), 32'h1000_03FC + 32'(k));
        do_write(0, 10'h3FF, 32'h1234_5678);
        for (int k = 0; k < 4; k++) do_write(0, 10'h010 + 10'(k), 32'hB0 + 32'(k));
        do_write(0, 10'h005, 32'h0000_0011);

        // Block fill from the middle of a block
        do_read(0, 10'h022, blk);
        check("fill_022", blk, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        prev = blk;

        // Write-through to the last word; neighbours and block register untouched
        do_write(0, 10'h3FF, 32'hDEAD_BEEF);
        check("blk_stable_after_wr", blk_a, prev);
        do_read(0, 10'h3FC, blk);
        check("fill_3fc", blk, {32'hDEAD_BEEF, 32'h1000_03FE, 32'h1000_03FD, 32'h1000_03FC});

        // Simultaneous requests: read served first with old data, then the write
        rd_a = 1'b1; wr_a = 1'b1; addr_a = 10'h010; wdat_a = 32'hCAFE_F00D;
        wait_ready(0, lat, idle);
        check("sim_rd_lat", lat, 9);
        check("sim_rd_old", blk_a, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        rd_a = 1'b0; addr_a = 10'h010; wdat_a = 32'hCAFE_F00D;
        wait_ready(0, lat, idle);
        check("sim_wr_lat", lat, 5);
        check("sim_wr_gap", idle, 1);
        wr_a = 1'b0;
        @(negedge clk);
        do_read(0, 10'h010, blk);
        check("sim_rd_new", blk, {32'hB3, 32'hB2, 32'hB1, 32'hCAFE_F00D});

        // Back-to-back reads with read_req held throughout
        rd_a = 1'b1; addr_a = 10'h020;
        wait_ready(0, lat, idle);
        check("b2b_lat1", lat, 9);
        check("b2b_blk1", blk_a, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        addr_a = 10'h3FC;
        wait_ready(0, lat, idle);
        check("b2b_gap", idle, 1);
        check("b2b_lat2", lat, 9);
        check("b2b_blk2", blk_a, {32'hDEAD_BEEF, 32'h1000_03FE, 32'h1000_03FD, 32'h1000_03FC});
        rd_a = 1'b0;
        @(negedge clk);
        check("b2b_rdy_drop", {127'd0, rdy_a}, 128'd0);

        // Reset in the second WAIT cycle of a write cancels it
        wr_a = 1'b1; addr_a = 10'h005; wdat_a = 32'h55;
        @(negedge clk);
        check("rw_busy_w1", {127'd0, busy_a}, 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_busy_now", {127'd0, busy_a}, 128'd0);
        check("rw_rdy_now",  {127'd0, rdy_a}, 128'd0);
        check("rw_blk_clr",  blk_a, 128'd0);
        wr_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rdy_a === 1'b1) pulses++;
        end
        check("rw_no_ready", pulses, 0);
        do_read(0, 10'h004, blk);
        check("rw_word_kept", blk[63:32], 32'h11);

        // LATENCY=1 instance
        do_write(1, 10'h031, 32'h7777_0031);
        do_read(1, 10'h033, blk);
        check("l1_word", blk[63:32], 32'h7777_0031);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_burst_ctrl.md
DMEM_BURST_CTRL -- requirements
Module: dmem_burst_ctrl

Interface
REQ-001 Parameter: LATENCY, default 4, wait cycles before the first data beat or the write commit; legal range 1..15.
REQ-002 Parameter: DEPTH, default 1024, number of 32-bit words in data memory.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 read_req  input  1  level request for a 4-word block fill; held by the cache controller until ready.
REQ-006 write_req  input  1  level request for a single-word write-through; held until ready.
REQ-007 word_address  input  10  word address of the request; bits [9:2] select the block and bits [1:0] select the word.
REQ-008 write_data  input  32  store data; sampled at request acceptance.
REQ-009 ready  output  1  one-cycle completion pulse for the current request.
REQ-010 block_data  output  128  filled block; word n is at bits [32n+31:32n].
REQ-011 busy  output  1  high while a request is in progress.

Function
REQ-012 The FSM SHALL have four states: IDLE, WAIT, BURST and DONE.
REQ-013 IDLE SHALL accept read_req or write_req at a clock edge, latch word_address and write_data, clear the counter, and enter WAIT.
REQ-014 Simultaneous read_req and write_req SHALL be accepted as a read; the write is accepted on a later IDLE cycle if it is still held.
REQ-015 WAIT SHALL last exactly LATENCY cycles; it then exits to BURST for a read, or commits the write and exits to DONE for a write.
REQ-016 BURST SHALL last exactly 4 cycles, with the beat counter running 0..3.
  - Each beat loads memory word {addr[9:2], beat} into block_data slot [beat].
  - block_data is written only during BURST, so earlier data stays stable between fills.
REQ-017 A write SHALL update exactly one word, at the latched address, with the latched data, on the last WAIT cycle; no other word changes.
REQ-018 DONE SHALL assert ready for exactly one cycle and then return to IDLE.
REQ-019 IDLE SHALL NOT accept a request in the cycle immediately after DONE, giving the requester one cycle to deassert.
REQ-020 Read latency from acceptance to ready SHALL be LATENCY+5 cycles; write latency SHALL be LATENCY+1 cycles.
REQ-021 busy SHALL be high in WAIT, BURST and DONE, and low in IDLE.
REQ-022 Request deassertion before ready SHALL NOT abort the operation; it completes normally.
REQ-023 word_address changes after acceptance SHALL be ignored.
REQ-024 Burst word addresses SHALL NOT wrap past the end of the block; the block base is always addr[9:2]<<2.
REQ-025 All counters SHALL be 4 bits wide and saturate-free within the legal LATENCY range.

Reset
REQ-026 When rst is asserted, the block SHALL immediately force:
  - state to IDLE
  - ready = 0, busy = 0, block_data = 0
  - counters = 0
REQ-027 Reset during WAIT SHALL cancel a pending write, leaving the memory word unchanged.
REQ-028 Reset during BURST SHALL discard any partial fill.
REQ-029 Memory array contents SHALL NOT be cleared by rst.
REQ-030 The first request SHALL be accepted no earlier than the first rising clock edge after rst deasserts.

Structure
REQ-031 A shared package SHALL hold:
  - the state encoding, 2 bits: IDLE=00, WAIT=01, BURST=10, DONE=11
  - word/block/address width constants (32/128/10)
  - the LATENCY default
REQ-032 Storage SHALL be a sub-module dmem_array: DEPTH x 32, synchronous write, combinational read, no reset.
REQ-033 dmem_burst_ctrl SHALL contain the FSM, counters, the address/data latches and the block_data register.

Verification
REQ-034 Read fill: preload words 0x20..0x23 with 0xA0..0xA3, hold read_req with addr 0x22 → ready at cycle 9 after acceptance, block_data = {0xA3,0xA2,0xA1,0xA0}.
REQ-035 Write-through: write_req with addr 0x3FF and data 0xDEADBEEF → ready at cycle 5, word 0x3FF = 0xDEADBEEF, words 0x3FC..0x3FE unchanged.
REQ-036 Simultaneous requests: read_req and write_req both held at addr 0x10 → read completes first, write completes afterwards, a following read returns the new data.
REQ-037 Reset mid-write: pulse rst in the 2nd WAIT cycle of a write of 0x55 to addr 0x05 → ready never pulses, word 0x05 keeps its old value, busy = 0 immediately.
REQ-038 Back-to-back reads: read_req held continuously across two fills → exactly one idle cycle between DONE and the next WAIT, and ready is exactly 1 cycle wide each time.
REQ-039 LATENCY = 1 variant: read latency is 6 cycles and write latency is 2 cycles.
